// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction-time sequencer: random wait, GO stimulus, ms-resolution measurement, result reporting.
// Optional macro AVG_OUT_EN adds avg_ms (session sum divided by N_ROUNDS, N_ROUNDS a power of two).

// state  | meaning
// IDLE   | waiting for a start rising edge
// WAIT   | random pre-stimulus delay; any press is a false start
// GO     | led lit, timing the button press
// RESULT | publish result, then hold until the button is released
// FINISH | one-cycle session-complete pulse
module reaction_round_ctrl #(
    parameter int CLKS_PER_MS = 50000,
    parameter int N_ROUNDS    = 4,
    parameter int MIN_WAIT_MS = 1000,
    parameter int WAIT_MASK   = 1023,
    parameter int TIMEOUT_MS  = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn,
    output logic        led_go,
    output logic        busy,
    output logic [2:0]  round_idx,
    output logic        result_valid,
    output logic [15:0] result_ms,
    output logic        false_start,
    output logic        timeout,
    output logic [15:0] best_ms,
    output logic [18:0] sum_ms,
    output logic        done_tick
`ifdef AVG_OUT_EN
    ,
    output logic [15:0] avg_ms
`endif
);

    localparam int              PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0]   PRESC_TC   = PW'(CLKS_PER_MS - 1);
    localparam logic [15:0]     MIN_WAIT   = 16'(MIN_WAIT_MS);
    localparam logic [15:0]     MASK       = 16'(WAIT_MASK);
    localparam logic [15:0]     TIMEOUT    = 16'(TIMEOUT_MS);
    localparam logic [2:0]      LAST_ROUND = 3'(N_ROUNDS - 1);

`ifdef AVG_OUT_EN
    localparam int AVG_SH = $clog2(N_ROUNDS);
    if ((1 << AVG_SH) != N_ROUNDS) begin : g_avg_chk
        $error("reaction_round_ctrl: N_ROUNDS must be a power of two when AVG_OUT_EN is defined");
    end
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_RESULT,
        S_FINISH
    } state_t;

    state_t        state;
    logic          btn_meta;
    logic          btn_s;
    logic          btn_s_d;
    logic          start_d;
    logic [15:0]   lfsr;
    logic [PW-1:0] presc;
    logic [15:0]   ms_cnt;
    logic [15:0]   wait_target;
    logic          res_first;
    logic          res_timeout;

    logic          btn_rise;
    logic          start_rise;
    logic          ms_tick;
    logic          lfsr_fb;
    logic [15:0]   new_wait;

    assign btn_rise   = btn_s & ~btn_s_d;
    assign start_rise = start & ~start_d;
    // Prescaler counts down from the terminal count; reaching zero closes one millisecond.
    assign ms_tick    = (presc == '0);
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign new_wait   = MIN_WAIT + (lfsr & MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            btn_s_d  <= 1'b0;
            start_d  <= 1'b0;
            lfsr     <= 16'hACE1;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
            btn_s_d  <= btn_s;
            start_d  <= start;
            lfsr     <= {lfsr[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            presc        <= PRESC_TC;
            ms_cnt       <= '0;
            wait_target  <= '0;
            res_first    <= 1'b0;
            res_timeout  <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
            round_idx    <= '0;
            result_valid <= 1'b0;
            result_ms    <= '0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            best_ms      <= 16'hFFFF;
            sum_ms       <= '0;
            done_tick    <= 1'b0;
`ifdef AVG_OUT_EN
            avg_ms       <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            done_tick    <= 1'b0;
            presc        <= ms_tick ? PRESC_TC : presc - 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        round_idx   <= '0;
                        best_ms     <= 16'hFFFF;
                        sum_ms      <= '0;
                        wait_target <= new_wait;
                        busy        <= 1'b1;
                        state       <= S_WAIT;
                        presc       <= PRESC_TC;
                        ms_cnt      <= '0;
                    end
                end

                S_WAIT: begin
                    // A press restarts the wait with a fresh random target; it beats expiry.
                    if (btn_s) begin
                        false_start <= 1'b1;
                        wait_target <= new_wait;
                        presc       <= PRESC_TC;
                        ms_cnt      <= '0;
                    end else if (ms_cnt == wait_target) begin
                        led_go <= 1'b1;
                        state  <= S_GO;
                        presc  <= PRESC_TC;
                        ms_cnt <= '0;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end

                S_GO: begin
                    if (btn_rise) begin
                        result_ms   <= ms_cnt;
                        res_timeout <= 1'b0;
                        res_first   <= 1'b1;
                        led_go      <= 1'b0;
                        state       <= S_RESULT;
                        presc       <= PRESC_TC;
                        ms_cnt      <= '0;
                    end else if (ms_cnt == TIMEOUT) begin
                        result_ms   <= TIMEOUT;
                        res_timeout <= 1'b1;
                        res_first   <= 1'b1;
                        led_go      <= 1'b0;
                        state       <= S_RESULT;
                        presc       <= PRESC_TC;
                        ms_cnt      <= '0;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end

                S_RESULT: begin
                    // Publishing happens on the first RESULT cycle so timeout and result_valid coincide.
                    if (res_first) begin
                        res_first    <= 1'b0;
                        result_valid <= 1'b1;
                        timeout      <= res_timeout;
                        best_ms      <= (result_ms < best_ms) ? result_ms : best_ms;
                        sum_ms       <= sum_ms + 19'(result_ms);
                    end else if (!btn_s) begin
                        presc  <= PRESC_TC;
                        ms_cnt <= '0;
                        if (round_idx == LAST_ROUND) begin
                            done_tick <= 1'b1;
                            state     <= S_FINISH;
`ifdef AVG_OUT_EN
                            avg_ms    <= 16'(sum_ms >> AVG_SH);
`endif
                        end else begin
                            round_idx   <= round_idx + 1'b1;
                            wait_target <= new_wait;
                            state       <= S_WAIT;
                        end
                    end
                end

                S_FINISH: begin
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                    presc  <= PRESC_TC;
                    ms_cnt <= '0;
                end

                default: begin
                    busy   <= 1'b0;
                    led_go <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
Sequencer for multi-round reaction-time measurement on the 50 MHz board. On start it runs N_ROUNDS rounds. Each round has four steps: a pseudorandom wait, then the go LED turns on, then the block measures the time to the button press in milliseconds, then it reports the result. It detects false starts and timeouts, and accumulates best and total times for the display/UART logic downstream.

Parameters:
CLKS_PER_MS, 50000, clock cycles per millisecond (prescaler terminal count + 1); benches use 4
N_ROUNDS, 4, rounds per session (1..7)
MIN_WAIT_MS, 1000, fixed part of the random wait
WAIT_MASK, 1023, mask applied to LFSR for the random part (2^k-1)
TIMEOUT_MS, 2000, max reaction time; also the saturation value

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  session start; rising edge sampled; ignored while busy
btn  in  1  raw push-button, active-high; 2-flop synchronised internally
led_go  out  1  stimulus LED, high only in GO
busy  out  1  high in every state except IDLE
round_idx  out  3  current round, 0-based
result_valid  out  1  one-cycle pulse, result_ms valid
result_ms  out  16  reaction time of last completed round
false_start  out  1  one-cycle pulse, button during WAIT
timeout  out  1  one-cycle pulse, round hit TIMEOUT_MS
best_ms  out  16  minimum result this session
sum_ms  out  19  sum of results this session
done_tick  out  1  one-cycle pulse, session complete

Behaviour:
- Reset: state IDLE; all outputs 0 except best_ms=16'hFFFF; LFSR=16'hACE1; synchroniser and edge flops 0.
- btn_s: btn after 2 flops. btn_rise = btn_s & ~btn_s_d.
- start_rise is registered the same way, with no synchroniser.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in every state.
- ms timebase: prescaler 0..CLKS_PER_MS-1. ms_tick fires when the prescaler is at terminal count. The prescaler and ms_cnt clear on every state entry.
- IDLE: start_rise → round_idx=0, best_ms=FFFF, sum_ms=0, load wait_target=MIN_WAIT_MS+(lfsr&WAIT_MASK), go to WAIT.
- WAIT: ms_cnt increments on ms_tick.
  - btn_s high on any cycle → false_start pulse, reload wait_target from current LFSR, clear ms_cnt/prescaler, stay in WAIT. round_idx is unchanged.
  - ms_cnt==wait_target with btn_s low → GO.
  - btn_s high in the same cycle as expiry → the false start wins.
- GO: led_go=1; ms_cnt increments on ms_tick.
  - btn_rise → result_ms=ms_cnt (floor ms), go to RESULT.
  - Else ms_cnt==TIMEOUT_MS → result_ms=TIMEOUT_MS, timeout pulse, go to RESULT.
  - Press and timeout in the same cycle: the press wins.
- RESULT: on the entry cycle only:
  - result_valid=1.
  - best_ms=min(best_ms,result_ms).
  - sum_ms+=result_ms (19 bits; cannot overflow for N_ROUNDS≤7).
  - Remain in RESULT until btn_s==0.
  - Then, if round_idx==N_ROUNDS-1 → FINISH. Else round_idx+1, load a new wait_target, go to WAIT.
- FINISH: done_tick=1 for one cycle → IDLE. round_idx, result_ms, best_ms and sum_ms are held until the next start.
- start_rise outside IDLE is ignored.
- rst asserted mid-session returns everything to reset values immediately.
- Latency:
  - Press → result_valid: 4 cycles (2 sync + 1 edge + 1 state).
  - led_go rises on the cycle after the WAIT expiry compare.

Optional Feature:
AVG_OUT_EN
- Defined: adds output avg_ms [15:0] = sum_ms >> log2(N_ROUNDS), registered on entry to FINISH and reset to 0. N_ROUNDS must then be a power of 2; an elaboration-time error is raised otherwise.
- Undefined: no avg_ms port and no extra logic.

Test Plan:
All scenarios use CLKS_PER_MS=4, N_ROUNDS=2, MIN_WAIT_MS=3, WAIT_MASK=3, TIMEOUT_MS=20.
- Nominal: start, press 7 ms after led_go rises in each round → two result_valid pulses with result_ms=7, best_ms=7, sum_ms=14, done_tick once, round_idx ends at 1.
- False start: btn high during WAIT of round 0 → false_start pulse, led_go stays 0, round_idx stays 0. After release the wait restarts and the round completes normally.
- Timeout: no press in GO → timeout pulse and result_valid in the same cycle, result_ms=20. Round 2 pressed at 5 ms → best_ms=5, sum_ms=25.
- Held button: keep btn high through RESULT for 30 cycles → no WAIT entry and no false_start until release.
- Start ignored while busy, and reset mid-GO: start pulse in WAIT has no effect. rst in GO → led_go=0, busy=0, best_ms=FFFF, sum_ms=0 next cycle.
- AVG_OUT_EN: results 6 and 9 → avg_ms=7 at FINISH.
